// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue queue: default sizes and operation select codes.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_DEPTH = 4;

    typedef enum logic [1:0] {
        SEL_ADD = 2'b00,
        SEL_SUB = 2'b01,
        SEL_INC = 2'b10,
        SEL_DEC = 2'b11
    } alu_sel_e;

endpackage

// File: rtl/arithmetic_unit.sv
// Purely combinational add/sub/inc/dec unit; results wrap modulo 2^WIDTH.
module arithmetic_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [1:0]       sel_i,
    output logic [WIDTH-1:0] result_o
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Select the operation; carry and borrow fall off the top bit.
    always_comb begin
        // NOTE: default assignment first so no path leaves result_o unassigned (no latch).
        result_o = '0;
        case (alu_sel_e'(sel_i))
            SEL_ADD: result_o = a_i + b_i;
            SEL_SUB: result_o = a_i - b_i;
            SEL_INC: result_o = a_i + ONE;
            SEL_DEC: result_o = a_i - ONE;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_issue_queue.sv
// FIFO of pending ALU operations; the head entry is computed combinationally and
// captured, with its operands, into a registered valid/ready output stage.
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic [1:0]               in_sel,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_a,
    output logic [WIDTH-1:0]         out_b,
    output logic [1:0]               out_sel,
    output logic [WIDTH-1:0]         out_result,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    // Queue storage
    logic [WIDTH-1:0] mem_a   [DEPTH];
    logic [WIDTH-1:0] mem_b   [DEPTH];
    logic [1:0]       mem_sel [DEPTH];

    // Control state
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_a_q, out_a_d;
    logic [WIDTH-1:0] out_b_q, out_b_d;
    logic [1:0]       out_sel_q, out_sel_d;
    logic [WIDTH-1:0] out_result_q, out_result_d;

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] head_result;

    // Pop only from entries already stored, so a push into an empty queue never bypasses.
    assign in_ready = (count_q < DEPTH_C);
    assign push     = in_valid && in_ready;
    assign pop      = (count_q != '0) && (!out_valid_q || out_ready);

    arithmetic_unit #(
        .WIDTH (WIDTH)
    ) u_arith (
        .a_i      (mem_a[head_q]),
        .b_i      (mem_b[head_q]),
        .sel_i    (mem_sel[head_q]),
        .result_o (head_result)
    );

    // Next-state for pointers, occupancy and the output stage.
    always_comb begin
        head_d       = pop  ? head_q + PTR_ONE : head_q;
        tail_d       = push ? tail_q + PTR_ONE : tail_q;
        count_d      = count_q;
        out_valid_d  = out_valid_q;
        out_a_d      = out_a_q;
        out_b_d      = out_b_q;
        out_sel_d    = out_sel_q;
        out_result_d = out_result_q;

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (pop) begin
            out_valid_d  = 1'b1;
            out_a_d      = mem_a[head_q];
            out_b_d      = mem_b[head_q];
            out_sel_d    = mem_sel[head_q];
            out_result_d = head_result;
        end else if (out_valid_q && out_ready) begin
            out_valid_d  = 1'b0;
        end
    end

    // Control registers: reset clears everything, flush drops queued and presented work.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all clocked state so every register samples pre-edge values.
        if (rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            out_valid_q  <= 1'b0;
            out_a_q      <= '0;
            out_b_q      <= '0;
            out_sel_q    <= '0;
            out_result_q <= '0;
        end else if (flush) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            out_valid_q  <= out_valid_d;
            out_a_q      <= out_a_d;
            out_b_q      <= out_b_d;
            out_sel_q    <= out_sel_d;
            out_result_q <= out_result_d;
        end
    end

    // Write the accepted operation into the tail entry.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; count_q guards every read, so stale entries are never used.
        if (!rst && !flush && push) begin
            mem_a[tail_q]   <= in_a;
            mem_b[tail_q]   <= in_b;
            mem_sel[tail_q] <= in_sel;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_a      = out_a_q;
    assign out_b      = out_b_q;
    assign out_sel    = out_sel_q;
    assign out_result = out_result_q;
    assign count      = count_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_alu_issue_queue;

    localparam int W   = 4;
    localparam int D   = 4;
    localparam int MOD = 1 << W;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   sel;
    } op_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic [1:0]     in_sel;
    logic           flush;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_a;
    logic [W-1:0]   out_b;
    logic [1:0]     out_sel;
    logic [W-1:0]   out_result;
    logic [2:0]     count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    op_t          mq[$];
    logic         m_valid;
    op_t          m_out;
    logic [W-1:0] m_result;

    alu_issue_queue #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_sel     (in_sel),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_sel    (out_sel),
        .out_result (out_result),
        .count      (count)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [1:0] sel);
        int r;
        case (sel)
            2'd0:    r = int'(a) + int'(b);
            2'd1:    r = int'(a) - int'(b);
            2'd2:    r = int'(a) + 1;
            default: r = int'(a) - 1;
        endcase
        r = ((r % MOD) + MOD) % MOD;
        return W'(r);
    endfunction

    // Advance the reference model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        logic do_push;
        logic do_pop;
        op_t  op;
        if (rst) begin
            mq.delete();
            m_valid  = 1'b0;
            m_out    = '{a: '0, b: '0, sel: '0};
            m_result = '0;
        end else if (flush) begin
            mq.delete();
            m_valid = 1'b0;
        end else begin
            do_push = in_valid && (mq.size() < D);
            do_pop  = (mq.size() > 0) && (!m_valid || out_ready);
            if (do_pop) begin
                op       = mq.pop_front();
                m_out    = op;
                m_result = calc(op.a, op.b, op.sel);
                m_valid  = 1'b1;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
            if (do_push) mq.push_back('{a: in_a, b: in_b, sel: in_sel});
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] sel);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sel   = sel;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        in_a = '0; in_b = '0; in_sel = '0;
        do_reset();
        checks++;
        if (count !== 3'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got count=%0d in_ready=%b out_valid=%b exp 0/1/0",
                     count, in_ready, out_valid);
        end
        checks++;
        if (out_a !== 4'd0 || out_b !== 4'd0 || out_sel !== 2'd0 || out_result !== 4'd0) begin
            errors++;
            $display("FAIL reset_data got a=%h b=%h sel=%h res=%h exp all 0",
                     out_a, out_b, out_sel, out_result);
        end
    endtask

    task automatic test_basic();
        do_reset();
        out_ready = 1'b1;
        drive_op(4'b0111, 4'b0100, 2'b00);
        step();
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_edge1 got count=%0d out_valid=%b exp 1/0", count, out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_result !== 4'b1011 || count !== 3'd0) begin
            errors++;
            $display("FAIL basic_edge2 got valid=%b res=%b count=%0d exp 1/1011/0",
                     out_valid, out_result, count);
        end
    endtask

    task automatic test_fill();
        int exp_cnt[6] = '{1, 1, 2, 3, 4, 4};
        do_reset();
        out_ready = 1'b0;
        drive_op(4'b0111, 4'b0110, 2'b01);
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (count !== 3'(exp_cnt[i])) begin
                errors++;
                $display("FAIL fill_count cycle %0d got %0d exp %0d", i, count, exp_cnt[i]);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 4'b0001) begin
            errors++;
            $display("FAIL fill_full got in_ready=%b valid=%b res=%b exp 0/1/0001",
                     in_ready, out_valid, out_result);
        end
    endtask

    task automatic test_drain_wrap();
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive_op(W'(k + 3), W'($urandom_range(0, MOD - 1)), 2'($urandom_range(0, 3)));
            step();
            checks++;
            if (out_valid !== 1'b1 || out_a !== m_out.a || out_b !== m_out.b ||
                out_sel !== m_out.sel || out_result !== m_result) begin
                errors++;
                $display("FAIL drain_wrap cycle %0d got v=%b a=%h b=%h s=%h r=%h exp v=1 a=%h b=%h s=%h r=%h",
                         k, out_valid, out_a, out_b, out_sel, out_result,
                         m_out.a, m_out.b, m_out.sel, m_result);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_edge_cases();
        logic [W-1:0] ea[3]  = '{4'b1111, 4'b0000, 4'b0110};
        logic [W-1:0] eb[3]  = '{4'b0001, 4'b0000, 4'b0111};
        logic [1:0]   es[3]  = '{2'b00, 2'b11, 2'b01};
        logic [W-1:0] exp[3] = '{4'b0000, 4'b1111, 4'b1111};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive_op(ea[i], eb[i], es[i]);
            else in_valid = 1'b0;
            step();
            if (i >= 1) begin
                checks++;
                if (out_valid !== 1'b1 || out_result !== exp[i-1]) begin
                    errors++;
                    $display("FAIL edge_case %0d got valid=%b res=%b exp 1/%b",
                             i - 1, out_valid, out_result, exp[i-1]);
                end
            end
        end
    endtask

    task automatic test_stall();
        op_t          ops[3];
        logic [W-1:0] s_a, s_b, s_r;
        logic [1:0]   s_s;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ops[i] = '{a: W'($urandom_range(0, MOD - 1)), b: W'($urandom_range(0, MOD - 1)),
                       sel: 2'($urandom_range(0, 3))};
            drive_op(ops[i].a, ops[i].b, ops[i].sel);
            step();
        end
        in_valid = 1'b0;
        s_a = out_a; s_b = out_b; s_s = out_sel; s_r = out_result;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_a !== s_a || out_b !== s_b ||
                out_sel !== s_s || out_result !== s_r || out_a !== ops[0].a) begin
                errors++;
                $display("FAIL stall_hold cycle %0d got v=%b a=%h r=%h exp v=1 a=%h r=%h",
                         i, out_valid, out_a, out_result, ops[0].a, s_r);
            end
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_a !== ops[1].a || out_b !== ops[1].b ||
            out_result !== calc(ops[1].a, ops[1].b, ops[1].sel)) begin
            errors++;
            $display("FAIL stall_release got v=%b a=%h r=%h exp v=1 a=%h r=%h",
                     out_valid, out_a, out_result, ops[1].a, calc(ops[1].a, ops[1].b, ops[1].sel));
        end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_op(W'(i + 1), W'(i), 2'b00);
            step();
        end
        checks++;
        if (count !== 3'd3 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre got count=%0d valid=%b exp 3/1", count, out_valid);
        end
        flush     = 1'b1;
        out_ready = 1'b1;
        drive_op(4'hA, 4'h5, 2'b00);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_now got count=%0d valid=%b in_ready=%b exp 0/0/1",
                     count, out_valid, in_ready);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (count !== 3'd0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_after cycle %0d got count=%0d valid=%b exp 0/0",
                         i, count, out_valid);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 79) == 0);
            flush     = ($urandom_range(0, 24) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            drive_op(W'($urandom_range(0, MOD - 1)), W'($urandom_range(0, MOD - 1)),
                     2'($urandom_range(0, 3)));
            in_valid  = ($urandom_range(0, 3) != 0);
            step();
            checks++;
            if (count !== 3'(mq.size()) || in_ready !== (mq.size() < D) || out_valid !== m_valid) begin
                errors++;
                $display("FAIL rand_ctrl cycle %0d got count=%0d in_ready=%b valid=%b exp %0d/%b/%b",
                         i, count, in_ready, out_valid, mq.size(), (mq.size() < D), m_valid);
            end
            if (m_valid) begin
                checks++;
                if (out_a !== m_out.a || out_b !== m_out.b || out_sel !== m_out.sel ||
                    out_result !== m_result) begin
                    errors++;
                    $display("FAIL rand_data cycle %0d got a=%h b=%h s=%h r=%h exp a=%h b=%h s=%h r=%h",
                             i, out_a, out_b, out_sel, out_result,
                             m_out.a, m_out.b, m_out.sel, m_result);
                end
            end
        end
        rst      = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_drain_wrap();
        test_edge_cases();
        test_stall();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
